// File: rtl/morse_pkg.sv
// morse_pkg
// Shared definitions for the Morse symbol transmitter:
//   - symbol code constants (digits 0-9, letters 10-35, word space 36)
//   - sequencer state enum
//   - pattern struct: element count plus a left-aligned dot/dash field
//   - element and gap durations expressed in Morse units
package morse_pkg;

  localparam logic [5:0] SYM_SPACE     = 6'd36;
  localparam logic [5:0] SYM_MAX_LEGAL = 6'd36;
  // Highest code that carries a dot/dash pattern (letter Z).
  localparam logic [5:0] SYM_MAX_CHAR  = 6'd35;

  // Durations in Morse units.
  localparam int DOT  = 1;
  localparam int DASH = 3;
  localparam int EGAP = 1;
  localparam int CGAP = 3;
  localparam int WGAP = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_ELEM_GAP,
    ST_CHAR_GAP,
    ST_WORD_GAP
  } state_t;

  // elems is MSB-first: element 0 sits in elems[4], 1 = dash, 0 = dot.
  // Patterns shorter than five elements are left-aligned, low bits unused.
  typedef struct packed {
    logic [2:0] len;
    logic [4:0] elems;
  } pattern_t;

  function automatic pattern_t mk_pat(input logic [2:0] len, input logic [4:0] elems);
    pattern_t p;
    p.len   = len;
    p.elems = elems;
    return p;
  endfunction

endpackage

// File: rtl/morse_rom.sv
// morse_rom
// Purely combinational symbol-code to Morse pattern lookup.
// Ports:
//   sym_code  in  6  symbol index (0-9 digits, 10-35 letters A-Z)
//   valid     out 1  code carries a dot/dash pattern (0-35 only)
//   pattern   out 8  {len[2:0], elems[4:0]}, elems left-aligned MSB-first
// Word space (36) and illegal codes return valid = 0; the sequencer tells
// them apart itself.
module morse_rom
  import morse_pkg::*;
(
  input  logic [5:0] sym_code,
  output logic       valid,
  output pattern_t   pattern
);

  always_comb begin
    valid   = 1'b1;
    pattern = mk_pat(3'd0, 5'b00000);
    case (sym_code)
      // digits
      6'd0:  pattern = mk_pat(3'd5, 5'b11111);
      6'd1:  pattern = mk_pat(3'd5, 5'b01111);
      6'd2:  pattern = mk_pat(3'd5, 5'b00111);
      6'd3:  pattern = mk_pat(3'd5, 5'b00011);
      6'd4:  pattern = mk_pat(3'd5, 5'b00001);
      6'd5:  pattern = mk_pat(3'd5, 5'b00000);
      6'd6:  pattern = mk_pat(3'd5, 5'b10000);
      6'd7:  pattern = mk_pat(3'd5, 5'b11000);
      6'd8:  pattern = mk_pat(3'd5, 5'b11100);
      6'd9:  pattern = mk_pat(3'd5, 5'b11110);
      // letters A-Z
      6'd10: pattern = mk_pat(3'd2, 5'b01000); // A .-
      6'd11: pattern = mk_pat(3'd4, 5'b10000); // B -...
      6'd12: pattern = mk_pat(3'd4, 5'b10100); // C -.-.
      6'd13: pattern = mk_pat(3'd3, 5'b10000); // D -..
      6'd14: pattern = mk_pat(3'd1, 5'b00000); // E .
      6'd15: pattern = mk_pat(3'd4, 5'b00100); // F ..-.
      6'd16: pattern = mk_pat(3'd3, 5'b11000); // G --.
      6'd17: pattern = mk_pat(3'd4, 5'b00000); // H ....
      6'd18: pattern = mk_pat(3'd2, 5'b00000); // I ..
      6'd19: pattern = mk_pat(3'd4, 5'b01110); // J .---
      6'd20: pattern = mk_pat(3'd3, 5'b10100); // K -.-
      6'd21: pattern = mk_pat(3'd4, 5'b01000); // L .-..
      6'd22: pattern = mk_pat(3'd2, 5'b11000); // M --
      6'd23: pattern = mk_pat(3'd2, 5'b10000); // N -.
      6'd24: pattern = mk_pat(3'd3, 5'b11100); // O ---
      6'd25: pattern = mk_pat(3'd4, 5'b01100); // P .--.
      6'd26: pattern = mk_pat(3'd4, 5'b11010); // Q --.-
      6'd27: pattern = mk_pat(3'd3, 5'b01000); // R .-.
      6'd28: pattern = mk_pat(3'd3, 5'b00000); // S ...
      6'd29: pattern = mk_pat(3'd1, 5'b10000); // T -
      6'd30: pattern = mk_pat(3'd3, 5'b00100); // U ..-
      6'd31: pattern = mk_pat(3'd4, 5'b00010); // V ...-
      6'd32: pattern = mk_pat(3'd3, 5'b01100); // W .--
      6'd33: pattern = mk_pat(3'd4, 5'b10010); // X -..-
      6'd34: pattern = mk_pat(3'd4, 5'b10110); // Y -.--
      6'd35: pattern = mk_pat(3'd4, 5'b11000); // Z --..
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_symbol_tx.sv
// morse_symbol_tx
// Accepts one symbol per valid/ready handshake and plays it out as a timed
// Morse key line using standard unit timing.
// Ports:
//   clk        in  1  system clock
//   rst        in  1  synchronous active-high reset
//   in_valid   in  1  sym_code valid
//   sym_code   in  6  0-9 digits, 10-35 letters, 36 word space, else illegal
//   in_ready   out 1  high only in IDLE
//   key_out    out 1  high during marks
//   elem_dash  out 1  current/last mark is a dash, held through gaps
//   busy       out 1  high in any state other than IDLE
//   done       out 1  pulse on the final cycle of a trailing/word gap
//   sym_err    out 1  pulse in the cycle after an illegal code is accepted
// Parameter UNIT_CYCLES (>= 1): clock cycles per Morse unit.
module morse_symbol_tx
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [5:0] sym_code,
  output logic       in_ready,
  output logic       key_out,
  output logic       elem_dash,
  output logic       busy,
  output logic       done,
  output logic       sym_err
);

  localparam int CW = $clog2(WGAP * UNIT_CYCLES + 1);

  // Counter load values: a state lasting N cycles loads N-1 and leaves at 0.
  localparam logic [CW-1:0] LD_DOT  = CW'(DOT  * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] LD_DASH = CW'(DASH * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] LD_EGAP = CW'(EGAP * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] LD_CGAP = CW'(CGAP * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] LD_WGAP = CW'(WGAP * UNIT_CYCLES - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [4:0]    elems_reg, elems_next;  // current element always in bit 4
  logic [2:0]    rem_reg, rem_next;      // elements still to play after the current one
  logic          dash_reg, dash_next;
  logic          err_reg, err_next;

  logic          rom_valid;
  pattern_t      rom_pat;

  morse_rom u_rom (
    .sym_code (sym_code),
    .valid    (rom_valid),
    .pattern  (rom_pat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      elems_reg <= '0;
      rem_reg   <= '0;
      dash_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      elems_reg <= elems_next;
      rem_reg   <= rem_next;
      dash_reg  <= dash_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    elems_next = elems_reg;
    rem_next   = rem_reg;
    dash_next  = dash_reg;
    err_next   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          if (rom_valid) begin
            state_next = ST_MARK;
            elems_next = rom_pat.elems;
            rem_next   = rom_pat.len - 3'd1;
            dash_next  = rom_pat.elems[4];
            cnt_next   = rom_pat.elems[4] ? LD_DASH : LD_DOT;
          end else if (sym_code == SYM_SPACE) begin
            state_next = ST_WORD_GAP;
            cnt_next   = LD_WGAP;
          end else begin
            // Illegal code: flag it and keep in_ready high.
            err_next = 1'b1;
          end
        end
      end

      ST_MARK: begin
        if (cnt_reg == '0) begin
          if (rem_reg != 3'd0) begin
            state_next = ST_ELEM_GAP;
            cnt_next   = LD_EGAP;
          end else begin
            state_next = ST_CHAR_GAP;
            cnt_next   = LD_CGAP;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      ST_ELEM_GAP: begin
        if (cnt_reg == '0) begin
          // Shift the next element into bit 4 as the mark starts.
          state_next = ST_MARK;
          elems_next = {elems_reg[3:0], 1'b0};
          rem_next   = rem_reg - 3'd1;
          dash_next  = elems_reg[3];
          cnt_next   = elems_reg[3] ? LD_DASH : LD_DOT;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      ST_CHAR_GAP, ST_WORD_GAP: begin
        if (cnt_reg == '0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs decode straight from registered state, so they change only at
  // clock edges and reset forces them to idle values at the reset edge.
  assign in_ready  = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign key_out   = (state_reg == ST_MARK);
  assign done      = ((state_reg == ST_CHAR_GAP) || (state_reg == ST_WORD_GAP)) &&
                     (cnt_reg == '0);
  assign elem_dash = dash_reg;
  assign sym_err   = err_reg;

endmodule

// File: tb/tb_morse_symbol_tx.sv
// Self-checking bench for morse_symbol_tx at UNIT_CYCLES = 4.
// Accepted symbols push their expected per-cycle output vectors
// {busy, in_ready, key_out, done, elem_dash, sym_err} into a queue built from
// a textual dot/dash table; a monitor pops and compares one entry per cycle.
// Scenario tasks add their own direct checks on top.
module tb_morse_symbol_tx;

  localparam int U = 4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [5:0] sym_code;
  logic       in_ready;
  logic       key_out;
  logic       elem_dash;
  logic       busy;
  logic       done;
  logic       sym_err;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  logic [5:0] exp_q[$];
  bit         mon_en     = 0;
  bit         model_dash = 0;

  string tbl [0:35] = '{
    "-----", ".----", "..---", "...--", "....-",
    ".....", "-....", "--...", "---..", "----.",
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
    ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
    "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."
  };

  morse_symbol_tx #(.UNIT_CYCLES(U)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .sym_code  (sym_code),
    .in_ready  (in_ready),
    .key_out   (key_out),
    .elem_dash (elem_dash),
    .busy      (busy),
    .done      (done),
    .sym_err   (sym_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: one comparison per cycle once reset has settled.
  always @(negedge clk) begin
    logic [5:0] obs;
    logic [5:0] expv;
    if (mon_en) begin
      obs = {busy, in_ready, key_out, done, elem_dash, sym_err};
      if (exp_q.size() > 0) expv = exp_q.pop_front();
      else                  expv = {1'b0, 1'b1, 1'b0, 1'b0, model_dash, 1'b0};
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("FAIL cycle_outputs at cycle %0d: got {busy,rdy,key,done,dash,err}=%b expected %b",
                 cyc, obs, expv);
      end
    end
  end

  task automatic push_expected(input logic [5:0] code);
    string s;
    bit    d;
    int    n;
    if (code <= 6'd35) begin
      s = tbl[code];
      d = 1'b0;
      for (int i = 0; i < s.len(); i++) begin
        d = (s[i] == "-");
        n = (d ? 3 : 1) * U;
        for (int k = 0; k < n; k++) exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, d, 1'b0});
        if (i < s.len() - 1)
          for (int k = 0; k < U; k++) exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, d, 1'b0});
      end
      n = 3 * U;
      for (int k = 0; k < n; k++) exp_q.push_back({1'b1, 1'b0, 1'b0, (k == n - 1), d, 1'b0});
      model_dash = d;
    end else if (code == 6'd36) begin
      n = 7 * U;
      for (int k = 0; k < n; k++)
        exp_q.push_back({1'b1, 1'b0, 1'b0, (k == n - 1), model_dash, 1'b0});
    end else begin
      exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, model_dash, 1'b1});
    end
  endtask

  // Offer a code, wait (bounded) for in_ready, and return at handshake edge + 1.
  task automatic send(input logic [5:0] code, input bit hold);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    sym_code = code;
    while (in_ready !== 1'b1 && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    tests_run++;
    if (guard >= 2000) begin
      tests_failed++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, guard);
    end
    @(posedge clk); #1;
    push_expected(code);
    $display("[TB] cycle %0d accepted code %0d", cyc, code);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    in_valid = 1'b0;
    sym_code = '0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({in_ready, key_out, elem_dash, busy, done, sym_err} !== 6'b100000) begin
      tests_failed++;
      $display("FAIL reset_values: got {rdy,key,dash,busy,done,err}=%b expected 100000",
               {in_ready, key_out, elem_dash, busy, done, sym_err});
    end
    rst    = 1'b0;
    mon_en = 1;
    $display("[TB] reset released at cycle %0d", cyc);
  endtask

  task automatic test_letter_e;
    int hi, bz, dn;
    hi = 0; bz = 0; dn = 0;
    send(6'd14, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hi += int'(key_out);
      bz += int'(busy);
      dn += int'(done);
    end
    tests_run++;
    if (hi != 4 || bz != 16 || dn != 1) begin
      tests_failed++;
      $display("FAIL letter_e: key_high=%0d busy=%0d done=%0d, expected 4 16 1", hi, bz, dn);
    end
  endtask

  task automatic test_digit_one;
    int hi, bz;
    hi = 0; bz = 0;
    send(6'd1, 0);
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      hi += int'(key_out);
      bz += int'(busy);
    end
    tests_run++;
    if (hi != 52 || bz != 80) begin
      tests_failed++;
      $display("FAIL digit_one: key_high=%0d busy=%0d, expected 52 80", hi, bz);
    end
  endtask

  task automatic test_back_to_back;
    int c0, hi;
    send(6'd36, 1);
    c0 = cyc;
    send(6'd29, 1);
    tests_run++;
    if (cyc - c0 != 29) begin
      tests_failed++;
      $display("FAIL back_to_back_spacing: %0d cycles between acceptances, expected 29", cyc - c0);
    end
    in_valid = 1'b0;
    hi = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      hi += int'(key_out);
    end
    tests_run++;
    if (hi != 12) begin
      tests_failed++;
      $display("FAIL back_to_back_t: key_high=%0d expected 12", hi);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_illegal;
    send(6'd40, 0);
    tests_run++;
    if ({sym_err, busy, key_out, in_ready} !== 4'b1001) begin
      tests_failed++;
      $display("FAIL illegal_code: got {err,busy,key,rdy}=%b expected 1001",
               {sym_err, busy, key_out, in_ready});
    end
    send(6'd10, 0);
    tests_run++;
    if ({busy, key_out, sym_err, elem_dash} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL accept_after_illegal: got {busy,key,err,dash}=%b expected 1100",
               {busy, key_out, sym_err, elem_dash});
    end
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_abort;
    int dn;
    dn = 0;
    send(6'd0, 0);
    repeat (19) @(posedge clk);
    #1;
    tests_run++;
    if (key_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_pre_key: key_out=%b expected 1", key_out);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    model_dash = 0;
    tests_run++;
    if ({key_out, busy, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL abort_edge: got {key,busy,done}=%b expected 000", {key_out, busy, done});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_ready: in_ready=%b expected 1", in_ready);
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      dn += int'(done);
    end
    tests_run++;
    if (dn != 0) begin
      tests_failed++;
      $display("FAIL abort_no_done: done seen %0d times, expected 0", dn);
    end
  endtask

  task automatic drain;
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk); #1;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expected cycles left, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_letter_e;
    test_digit_one;
    test_back_to_back;
    test_illegal;
    test_reset_abort;
    drain;
    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
